// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, sequencer states and destination selects
//
// Purpose: common definitions for cpu_sequencer and cpu_fetch.
// Ports:   none (package).
package cpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH_HI = 3'd1,
      S_FETCH_LO = 3'd2,
      S_EXEC     = 3'd3,
      S_HALT     = 3'd4
   } state_t;

   localparam logic [2:0] D_NONE = 3'd5;
   localparam logic [2:0] D_PC   = 3'd7;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ALU = 4'd1;
   localparam logic [3:0] OP_LDI = 4'd2;
   localparam logic [3:0] OP_JMP = 4'd3;
   localparam logic [3:0] OP_BZ  = 4'd4;
   localparam logic [3:0] OP_HLT = 4'd5;

   // Register-file destinations 5 and 6 are not writable; both collapse to
   // D_NONE so the register file only ever sees one "no write" code.
   function automatic logic [2:0] dest_sel(input logic [2:0] d);
      return ((d == 3'd5) || (d == 3'd6)) ? D_NONE : d;
   endfunction

endpackage

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - two-byte instruction fetch handshake and instruction register
//
// Purpose: drives the byte-wide instruction-memory request for the high and
//          low instruction bytes and captures them into ins.
// Ports:   clk, rst_n     clock, asynchronous active-low reset
//          state          sequencer state (owned by cpu_sequencer)
//          pc_out         current program counter
//          imem_req/addr  request and byte address to instruction memory
//          imem_ack/data  acknowledge and same-cycle data from memory
//          ins            captured 16-bit instruction
//          ins_valid      high for the single cycle after the low byte lands
module cpu_fetch
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  state_t      state,
   input  logic [7:0]  pc_out,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_data,
   output logic [15:0] ins,
   output logic        ins_valid
);

   // Request and address are pure decode of the state register, so they stay
   // stable while an ack is withheld and drop the instant reset forces IDLE.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = 8'd0;
      if (state == S_FETCH_HI) begin
         imem_req  = 1'b1;
         imem_addr = pc_out;
      end else if (state == S_FETCH_LO) begin
         imem_req  = 1'b1;
         imem_addr = pc_out + 8'd1;
      end
   end

   // Acks are only honoured in the two fetch states; anything else is stray.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins       <= 16'd0;
         ins_valid <= 1'b0;
      end else begin
         ins_valid <= (state == S_FETCH_LO) && imem_ack;
         if ((state == S_FETCH_HI) && imem_ack)
            ins[15:8] <= imem_data;
         if ((state == S_FETCH_LO) && imem_ack)
            ins[7:0] <= imem_data;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer for an 8-bit CPU
//
// Purpose: sequences IDLE -> FETCH_HI -> FETCH_LO -> EXEC and decodes the
//          fetched instruction into register-file and ALU controls.
// Ports:   clk, rst_n            clock, asynchronous active-low reset
//          run                   start request (IDLE/HALT only)
//          pc_out, rx_val        PC and rx read value from the register file
//          imem_req/addr/ack/data instruction-memory handshake
//          d_op, rx_op, ry_op    destination and source selects
//          pc_in                 next PC to the register file
//          wsel                  write-data select (0 ALU, 1 imm)
//          imm, alu_op           immediate and ALU operation
//          halted, illegal       status flags
module cpu_sequencer
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [7:0] pc_out,
   input  logic [7:0] rx_val,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic [2:0] d_op,
   output logic [2:0] rx_op,
   output logic [2:0] ry_op,
   output logic [7:0] pc_in,
   output logic       wsel,
   output logic [7:0] imm,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic       illegal
);

   state_t      state, state_nxt;
   logic [15:0] ins;
   logic        ins_valid;
   logic [3:0]  op;

   assign op     = ins[15:12];
   assign halted = (state == S_HALT);

   cpu_fetch u_fetch (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .pc_out    (pc_out),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .ins       (ins),
      .ins_valid (ins_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (run)      state_nxt = S_FETCH_HI;
         S_FETCH_HI: if (imem_ack) state_nxt = S_FETCH_LO;
         S_FETCH_LO: if (imem_ack) state_nxt = S_EXEC;
         S_EXEC:     state_nxt = (op >= OP_HLT) ? S_HALT : S_FETCH_HI;
         S_HALT:     if (run)      state_nxt = S_FETCH_HI;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // illegal is sticky through HALT and clears on the restart edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal <= 1'b0;
      else if ((state == S_EXEC) && (op > OP_HLT))
         illegal <= 1'b1;
      else if ((state == S_HALT) && run)
         illegal <= 1'b0;
   end

   // ins_valid is high exactly in EXEC, the only cycle allowed to commit.
   // Outside it every select idles and pc_in mirrors pc_out so the PC holds.
   always_comb begin
      d_op   = D_NONE;
      rx_op  = 3'd0;
      ry_op  = 3'd0;
      alu_op = 3'd0;
      wsel   = 1'b0;
      imm    = 8'd0;
      pc_in  = pc_out;
      if (ins_valid) begin
         rx_op = ins[8:6];
         ry_op = ins[5:3];
         pc_in = pc_out + 8'd2;
         case (op)
            OP_NOP, OP_HLT: begin
            end
            OP_ALU: begin
               d_op   = dest_sel(ins[11:9]);
               alu_op = ins[2:0];
            end
            OP_LDI: begin
               d_op = dest_sel(ins[11:9]);
               imm  = ins[7:0];
               wsel = 1'b1;
            end
            OP_JMP: begin
               d_op = D_PC;
               imm  = ins[7:0];
               wsel = 1'b1;
            end
            OP_BZ: begin
               if (rx_val == 8'd0) begin
                  d_op = D_PC;
                  imm  = ins[7:0];
                  wsel = 1'b1;
               end
            end
            default: pc_in = pc_out;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [7:0] pc_out = 8'h37;
   logic [7:0] rx_val = 8'd0;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'd0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [2:0] d_op, rx_op, ry_op, alu_op;
   logic [7:0] pc_in, imm;
   logic       wsel, halted, illegal;

   int checks = 0;
   int errors = 0;

   cpu_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .pc_out    (pc_out),
      .rx_val    (rx_val),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .d_op      (d_op),
      .rx_op     (rx_op),
      .ry_op     (ry_op),
      .pc_in     (pc_in),
      .wsel      (wsel),
      .imm       (imm),
      .alu_op    (alu_op),
      .halted    (halted),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] hi, lo, pc, rxv;
      int         dhi, dlo;
      logic [2:0] d, rx, ry, alu;
      logic       wsel;
      logic [7:0] imm, pcin;
      logic       halt, ill;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: instruction fields pulled out with integer arithmetic.
   function automatic vec_t model(input logic [7:0] hi, input logic [7:0] lo,
                                  input logic [7:0] pc, input logic [7:0] rxv,
                                  input int dhi, input int dlo);
      vec_t v;
      int w, op, d;
      w  = int'(hi) * 256 + int'(lo);
      op = w / 4096;
      d  = (w / 512) % 8;
      v.hi = hi; v.lo = lo; v.pc = pc; v.rxv = rxv; v.dhi = dhi; v.dlo = dlo;
      v.rx = 3'((w / 64) % 8);
      v.ry = 3'((w / 8) % 8);
      v.d = 3'd5; v.alu = 3'd0; v.wsel = 1'b0; v.imm = 8'd0;
      v.pcin = 8'((int'(pc) + 2) % 256);
      v.halt = 1'b0; v.ill = 1'b0;
      if (op == 1) begin
         v.d   = (d == 5 || d == 6) ? 3'd5 : 3'(d);
         v.alu = 3'(w % 8);
      end else if (op == 2) begin
         v.d    = (d == 5 || d == 6) ? 3'd5 : 3'(d);
         v.imm  = lo;
         v.wsel = 1'b1;
      end else if (op == 3 || (op == 4 && rxv == 8'd0)) begin
         v.d    = 3'd7;
         v.imm  = lo;
         v.wsel = 1'b1;
      end else if (op == 5) begin
         v.halt = 1'b1;
      end else if (op >= 6) begin
         v.pcin = pc;
         v.halt = 1'b1;
         v.ill  = 1'b1;
      end
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one instruction from a fresh reset; leaves DUT one cycle past EXEC.
   task automatic run_vec(input vec_t v);
      logic [7:0] a_lo;
      a_lo = 8'((int'(v.pc) + 1) % 256);
      do_reset();
      pc_out = v.pc;
      rx_val = v.rxv;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int i = 0; i < v.dhi; i++) begin
         chk("hi_wait_req", imem_req, 1);
         chk("hi_wait_addr", imem_addr, v.pc);
         chk("hi_wait_dop", d_op, 5);
         chk("hi_wait_pcin", pc_in, v.pc);
         run = 1'($urandom % 2);
         @(negedge clk);
      end
      chk("hi_req", imem_req, 1);
      chk("hi_addr", imem_addr, v.pc);
      run = 1'b0;
      imem_data = v.hi; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0; imem_data = 8'($urandom);
      for (int i = 0; i < v.dlo; i++) begin
         chk("lo_wait_req", imem_req, 1);
         chk("lo_wait_addr", imem_addr, a_lo);
         chk("lo_wait_dop", d_op, 5);
         chk("lo_wait_pcin", pc_in, v.pc);
         run = 1'($urandom % 2);
         @(negedge clk);
      end
      chk("lo_req", imem_req, 1);
      chk("lo_addr", imem_addr, a_lo);
      run = 1'b0;
      imem_data = v.lo; imem_ack = 1'b1;
      @(negedge clk);
      // EXEC: a stray ack and run here must have no effect.
      imem_data = 8'($urandom); imem_ack = 1'($urandom % 2);
      run = 1'($urandom % 2);
      chk("exec_dop", d_op, v.d);
      chk("exec_rx", rx_op, v.rx);
      chk("exec_ry", ry_op, v.ry);
      chk("exec_alu", alu_op, v.alu);
      chk("exec_wsel", wsel, v.wsel);
      chk("exec_imm", imm, v.imm);
      chk("exec_pcin", pc_in, v.pcin);
      chk("exec_req", imem_req, 0);
      @(negedge clk);
      run = 1'b0; imem_ack = 1'b0;
      chk("post_halted", halted, v.halt);
      chk("post_illegal", illegal, v.ill);
      chk("post_req", imem_req, !v.halt);
   endtask

   vec_t tbl[11];

   initial begin
      //         hi     lo     pc     rxv    dhi dlo d     rx    ry    alu   wsel  imm    pcin   halt  ill
      tbl[0]  = '{8'h25, 8'hAA, 8'h00, 8'h00, 1, 1, 3'd2, 3'd6, 3'd5, 3'd0, 1'b1, 8'hAA, 8'h02, 1'b0, 1'b0};
      tbl[1]  = '{8'h17, 8'h74, 8'h20, 8'h00, 0, 5, 3'd3, 3'd5, 3'd6, 3'd4, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0};
      tbl[2]  = '{8'h2C, 8'h11, 8'h30, 8'h00, 0, 0, 3'd5, 3'd0, 3'd2, 3'd0, 1'b1, 8'h11, 8'h32, 1'b0, 1'b0};
      tbl[3]  = '{8'h1E, 8'h00, 8'h40, 8'h00, 2, 0, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0};
      tbl[4]  = '{8'h30, 8'h99, 8'h50, 8'h00, 0, 1, 3'd7, 3'd2, 3'd3, 3'd0, 1'b1, 8'h99, 8'h52, 1'b0, 1'b0};
      tbl[5]  = '{8'h40, 8'h40, 8'h10, 8'h00, 1, 0, 3'd7, 3'd1, 3'd0, 3'd0, 1'b1, 8'h40, 8'h12, 1'b0, 1'b0};
      tbl[6]  = '{8'h40, 8'h40, 8'h10, 8'h03, 1, 0, 3'd5, 3'd1, 3'd0, 3'd0, 1'b0, 8'h00, 8'h12, 1'b0, 1'b0};
      tbl[7]  = '{8'h00, 8'h00, 8'hFE, 8'h00, 0, 0, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 0, 2, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0};
      tbl[9]  = '{8'h50, 8'h00, 8'h60, 8'h00, 0, 0, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h62, 1'b1, 1'b0};
      tbl[10] = '{8'hF0, 8'h00, 8'h70, 8'h00, 0, 0, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h70, 1'b1, 1'b1};

      // Reset state, with pc_out at a non-zero value.
      @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_dop", d_op, 5);
      chk("rst_rx", rx_op, 0);
      chk("rst_ry", ry_op, 0);
      chk("rst_alu", alu_op, 0);
      chk("rst_wsel", wsel, 0);
      chk("rst_imm", imm, 0);
      chk("rst_pcin", pc_in, 8'h37);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_wait_req", imem_req, 0);
      end

      foreach (tbl[i]) run_vec(tbl[i]);

      // After the illegal opcode: HALT holds, ignores stray acks, restarts on run.
      for (int i = 0; i < 3; i++) begin
         imem_ack = 1'b1; imem_data = 8'($urandom);
         @(negedge clk);
         chk("halt_req", imem_req, 0);
         chk("halt_halted", halted, 1);
         chk("halt_illegal", illegal, 1);
         chk("halt_pcin", pc_in, pc_out);
      end
      imem_ack = 1'b0;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("restart_halted", halted, 0);
      chk("restart_illegal", illegal, 0);
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, 8'h70);

      // Reset pulsed during FETCH_HI, followed by a late ack.
      do_reset();
      pc_out = 8'h84;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("mid_req_before", imem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_req_async", imem_req, 0);
      chk("mid_addr_async", imem_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_ack = 1'b1; imem_data = 8'h55;
      repeat (3) begin
         @(negedge clk);
         chk("mid_idle_req", imem_req, 0);
         chk("mid_idle_dop", d_op, 5);
      end
      imem_ack = 1'b0;

      // Randomised instructions against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [7:0] h, l, p, r;
         h = 8'($urandom); l = 8'($urandom); p = 8'($urandom);
         r = ($urandom % 2 == 0) ? 8'd0 : 8'($urandom);
         run_vec(model(h, l, p, r, int'($urandom % 3), int'($urandom % 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
